ram_bist: RTL and testbench



---
 rtl/ram_bist.sv | 206 ++++++++++++++++++++
 tb/tb_ram_bist.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// ram_bist -- built-in self-test sequencer for a single-port RAM.
//
// Runs a two-pass write/read-compare test over every address. Pass A writes
// PAT ^ addr and reads it back. Pass B writes the inverse and reads it back.
// Read data is checked against an expected value that is delayed to match
// the RAM read latency.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (aborts a run, no done)
//   start      in   single-cycle pulse, accepted only when idle
//   ram_din    out  RAM write data
//   ram_addr   out  RAM address
//   write_en   out  RAM write enable
//   ram_dout   in   RAM read data, valid RD_LAT cycles after ram_addr
//   busy       out  test in progress
//   done       out  one-cycle pulse when a test completes
//   pass       out  last completed test saw no mismatches
//   fail_addr  out  address of first mismatch
//   fail_data  out  data read at first mismatch
//   err_count  out  mismatch count, saturating at 255

module ram_bist #(
    parameter int                ADDR_W = 6,
    parameter int                DATA_W = 8,
    parameter int                RD_LAT = 1,
    parameter logic [DATA_W-1:0] PAT    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [DATA_W-1:0] ram_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              write_en,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [7:0]        err_count
);

    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WA,
        RA,
        DRA,
        WB,
        RB,
        DRB,
        FIN
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] pat_a;
    logic              issue;
    logic [DATA_W-1:0] issue_exp;

    logic              pipe_vld  [RD_LAT];
    logic [ADDR_W-1:0] pipe_addr [RD_LAT];
    logic [DATA_W-1:0] pipe_exp  [RD_LAT];

    logic              mismatch;

    assign pat_a    = PAT ^ DATA_W'(cnt);
    assign mismatch = pipe_vld[RD_LAT-1] && (ram_dout != pipe_exp[RD_LAT-1]);

    // State register. Reset is asynchronous so the RAM-facing outputs, which
    // are decoded from the state, drop as soon as rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode. Each state owns the RAM interface for its
    // phase. The address counter doubles as the drain counter in DRA/DRB.
    always_comb begin
        next_state = state;
        ram_din    = '0;
        ram_addr   = '0;
        write_en   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        issue      = 1'b0;
        issue_exp  = '0;
        unique case (state)
            IDLE: begin
                if (start) next_state = WA;
            end
            WA: begin
                busy     = 1'b1;
                write_en = 1'b1;
                ram_addr = cnt;
                ram_din  = pat_a;
                if (cnt == LAST_ADDR) next_state = RA;
            end
            RA: begin
                busy      = 1'b1;
                ram_addr  = cnt;
                issue     = 1'b1;
                issue_exp = pat_a;
                if (cnt == LAST_ADDR) next_state = DRA;
            end
            DRA: begin
                busy = 1'b1;
                if (cnt == DRAIN_LAST) next_state = WB;
            end
            WB: begin
                busy     = 1'b1;
                write_en = 1'b1;
                ram_addr = cnt;
                ram_din  = ~pat_a;
                if (cnt == LAST_ADDR) next_state = RB;
            end
            RB: begin
                busy      = 1'b1;
                ram_addr  = cnt;
                issue     = 1'b1;
                issue_exp = ~pat_a;
                if (cnt == LAST_ADDR) next_state = DRB;
            end
            DRB: begin
                busy = 1'b1;
                if (cnt == DRAIN_LAST) next_state = FIN;
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Phase counter. It restarts at zero on every state change, so the address
    // never runs past DEPTH-1 and each drain lasts exactly RD_LAT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (next_state != state || state == IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ADDR_W'(1);
        end
    end

    // Read-latency pipe. It carries the address and expected data of each issued
    // read, so the compare sees them in the cycle the RAM data arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_addr[i] <= '0;
                pipe_exp[i]  <= '0;
            end
        end else begin
            pipe_vld[0]  <= issue;
            pipe_addr[0] <= cnt;
            pipe_exp[0]  <= issue_exp;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
            end
        end
    end

    // Result registers. An accepted start clears them. A zero error count marks
    // the first mismatch, and it cannot return to zero because the count
    // saturates. pass is resolved on the edge into FIN, and that includes any
    // mismatch in the final drain cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            pass      <= 1'b0;
        end else if (state == IDLE && start) begin
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            pass      <= 1'b0;
        end else begin
            if (mismatch) begin
                if (err_count != 8'd255) err_count <= err_count + 8'd1;
                if (err_count == 8'd0) begin
                    fail_addr <= pipe_addr[RD_LAT-1];
                    fail_data <= ram_dout;
                end
            end
            if (state == DRB && next_state == FIN) begin
                pass <= (err_count == 8'd0) && !mismatch;
            end
        end
    end

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist -- self-checking bench for ram_bist.
//
// Two instances share clock, reset and start. dut1 has RD_LAT=1 and uses a RAM
// model with selectable latency and fault injection. dut2 has RD_LAT=2 and
// uses a clean 2-cycle RAM. Expected results come from a reference model that
// walks both test passes over every address.

module tb_ram_bist;

    localparam int          ADDR_W = 6;
    localparam int          DATA_W = 8;
    localparam int          DEPTH  = 64;
    localparam logic [7:0]  PAT    = 8'hA5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;

    logic [DATA_W-1:0] din1, dout1, fdata1, din2, dout2, fdata2;
    logic [ADDR_W-1:0] addr1, faddr1, addr2, faddr2;
    logic              we1, busy1, done1, pass1, we2, busy2, done2, pass2;
    logic [7:0]        err1, err2;

    ram_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .PAT(PAT)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ram_din(din1), .ram_addr(addr1), .write_en(we1), .ram_dout(dout1),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_addr(faddr1), .fail_data(fdata1), .err_count(err1)
    );

    ram_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .PAT(PAT)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ram_din(din2), .ram_addr(addr2), .write_en(we2), .ram_dout(dout2),
        .busy(busy2), .done(done2), .pass(pass2),
        .fail_addr(faddr2), .fail_data(fdata2), .err_count(err2)
    );

    // 10 ns clock period.
    always #5 clk = ~clk;

    // Fault configuration for the RAM model of dut1.
    bit         stuck_en = 1'b0;
    int         stuck_addr = 0;
    int         stuck_bit = 0;
    bit         stuck_val = 1'b0;
    logic [7:0] xor_mask = 8'h00;
    int         lat1 = 1;

    function automatic logic [7:0] fault(input logic [7:0] v, input int a);
        logic [7:0] r;
        r = v;
        if (stuck_en && a == stuck_addr) r[stuck_bit] = stuck_val;
        return r ^ xor_mask;
    endfunction

    // RAM models. dut1 sees an injected fault on read and has selectable latency.
    // dut2 always sees a clean RAM with 2-cycle latency.
    logic [7:0] mem1 [DEPTH];
    logic [7:0] mem2 [DEPTH];
    logic [7:0] r1a, r1b, r2a, r2b;

    always @(posedge clk) begin
        if (we1) mem1[addr1] <= din1;
        r1a <= fault(mem1[addr1], int'(addr1));
        r1b <= r1a;
        if (we2) mem2[addr2] <= din2;
        r2a <= mem2[addr2];
        r2b <= r2a;
    end

    assign dout1 = (lat1 == 2) ? r1b : r1a;
    assign dout2 = r2b;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: both passes, every address, with the current fault applied.
    int         m_err;
    int         m_faddr;
    logic [7:0] m_fdata;

    task automatic model_expect();
        logic [7:0] e, rd;
        m_err = 0; m_faddr = 0; m_fdata = 8'h00;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                e = PAT ^ 8'(a);
                if (p == 1) e = ~e;
                rd = fault(e, a);
                if (rd !== e) begin
                    if (m_err == 0) begin
                        m_faddr = a;
                        m_fdata = rd;
                    end
                    m_err = (m_err >= 255) ? 255 : m_err + 1;
                end
            end
        end
    endtask

    // Results of the most recent run.
    int r_b1, r_b2, r_d1, r_d2, r_di1, r_di2, r_w;
    bit r_busy0, r_rst_we, r_rst_busy, r_to;

    task automatic run_test(input int repulse_at, input int reset_at);
        bit finished;
        r_b1 = 0; r_b2 = 0; r_d1 = 0; r_d2 = 0; r_di1 = -1; r_di2 = -1; r_w = 0;
        r_busy0 = 1'b0; r_rst_we = 1'b1; r_rst_busy = 1'b1; finished = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int idx = 0; idx < 800 && !finished; idx++) begin
            if (idx == 0) r_busy0 = busy1;
            if (busy1) r_b1++;
            if (busy2) r_b2++;
            if (we1)   r_w++;
            if (done1) begin r_d1++; if (r_di1 < 0) r_di1 = idx; end
            if (done2) begin r_d2++; if (r_di2 < 0) r_di2 = idx; end
            start = (idx == repulse_at);
            if (idx == reset_at) begin
                rst_n = 1'b0;
                #1;
                r_rst_we   = we1;
                r_rst_busy = busy1;
            end else if (reset_at >= 0 && idx == reset_at + 1) begin
                rst_n = 1'b1;
            end
            if (reset_at >= 0) finished = (idx >= reset_at + 20);
            else finished = (r_d1 > 0 && r_d2 > 0 && idx >= r_di2 + 4);
            if (!finished) @(negedge clk);
        end
        start = 1'b0;
        r_to = !finished;
        n_cmp++;
        if (r_to) begin
            n_bad++;
            $display("[TB] FAIL run_timeout: run did not complete within 800 cycles");
        end
    endtask

    task automatic check_results(input string tag);
        model_expect();
        n_cmp++;
        if (err1 !== 8'(m_err)) begin
            n_bad++;
            $display("[TB] FAIL %s err_count: got %0d expected %0d", tag, err1, m_err);
        end
        n_cmp++;
        if (faddr1 !== 6'(m_faddr)) begin
            n_bad++;
            $display("[TB] FAIL %s fail_addr: got %0d expected %0d", tag, faddr1, m_faddr);
        end
        n_cmp++;
        if (fdata1 !== m_fdata) begin
            n_bad++;
            $display("[TB] FAIL %s fail_data: got %h expected %h", tag, fdata1, m_fdata);
        end
        n_cmp++;
        if (pass1 !== (m_err == 0)) begin
            n_bad++;
            $display("[TB] FAIL %s pass: got %b expected %b", tag, pass1, m_err == 0);
        end
    endtask

    task automatic clear_faults();
        stuck_en = 1'b0; xor_mask = 8'h00; lat1 = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy1, done1, pass1, we1, err1, faddr1, fdata1, addr1, din1} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_dut1: got %h expected 0",
                     {busy1, done1, pass1, we1, err1, faddr1, fdata1, addr1, din1});
        end
        n_cmp++;
        if ({busy2, done2, pass2, we2, err2, faddr2, fdata2, addr2, din2} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_dut2: got %h expected 0",
                     {busy2, done2, pass2, we2, err2, faddr2, fdata2, addr2, din2});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean();
        clear_faults();
        run_test(-1, -1);
        n_cmp++;
        if (r_busy0 !== 1'b1) begin
            n_bad++; $display("[TB] FAIL busy_rise: got %b expected 1", r_busy0);
        end
        n_cmp++;
        if (r_b1 != 4 * DEPTH + 2) begin
            n_bad++; $display("[TB] FAIL busy_cycles1: got %0d expected %0d", r_b1, 4 * DEPTH + 2);
        end
        n_cmp++;
        if (r_b2 != 4 * DEPTH + 4) begin
            n_bad++; $display("[TB] FAIL busy_cycles2: got %0d expected %0d", r_b2, 4 * DEPTH + 4);
        end
        n_cmp++;
        if (r_d1 != 1 || r_di1 != 4 * DEPTH + 2) begin
            n_bad++; $display("[TB] FAIL done1: got %0d pulses at %0d expected 1 at %0d", r_d1, r_di1, 4 * DEPTH + 2);
        end
        n_cmp++;
        if (r_d2 != 1 || r_di2 != 4 * DEPTH + 4) begin
            n_bad++; $display("[TB] FAIL done2: got %0d pulses at %0d expected 1 at %0d", r_d2, r_di2, 4 * DEPTH + 4);
        end
        n_cmp++;
        if (r_w != 2 * DEPTH) begin
            n_bad++; $display("[TB] FAIL write_count: got %0d expected %0d", r_w, 2 * DEPTH);
        end
        check_results("clean");
        n_cmp++;
        if (pass2 !== 1'b1 || err2 !== 8'd0) begin
            n_bad++; $display("[TB] FAIL clean_dut2: got pass %b err %0d expected pass 1 err 0", pass2, err2);
        end
    endtask

    task automatic test_stuck_bit();
        clear_faults();
        stuck_en = 1'b1; stuck_addr = 2; stuck_bit = 0; stuck_val = 1'b1;
        run_test(-1, -1);
        check_results("stuck_a2b0");
        for (int k = 0; k < 4; k++) begin
            stuck_addr = int'($urandom_range(DEPTH - 1, 0));
            stuck_bit  = int'($urandom_range(7, 0));
            stuck_val  = 1'($urandom_range(1, 0));
            run_test(-1, -1);
            check_results("stuck_random");
        end
    endtask

    task automatic test_xor_all();
        clear_faults();
        xor_mask = 8'h01;
        run_test(-1, -1);
        check_results("xor01");
        xor_mask = 8'($urandom_range(255, 1));
        run_test(-1, -1);
        check_results("xor_random");
    endtask

    task automatic test_back_to_back();
        clear_faults();
        run_test(50, -1);
        n_cmp++;
        if (r_d1 != 1 || r_di1 != 4 * DEPTH + 2) begin
            n_bad++; $display("[TB] FAIL restart_ignored: got %0d pulses at %0d expected 1 at %0d", r_d1, r_di1, 4 * DEPTH + 2);
        end
        check_results("restart_clears");
        xor_mask = 8'h10;
        run_test(-1, -1);
        check_results("rerun_faulted");
        xor_mask = 8'h00;
        run_test(-1, -1);
        check_results("rerun_clean");
    endtask

    task automatic test_reset_mid();
        clear_faults();
        xor_mask = 8'h02;
        run_test(-1, DEPTH + 10);
        n_cmp++;
        if (r_rst_we !== 1'b0 || r_rst_busy !== 1'b0) begin
            n_bad++; $display("[TB] FAIL async_reset: got we %b busy %b expected 0 0", r_rst_we, r_rst_busy);
        end
        n_cmp++;
        if (r_d1 != 0) begin
            n_bad++; $display("[TB] FAIL abort_no_done: got %0d done pulses expected 0", r_d1);
        end
        n_cmp++;
        if (err1 !== 8'd0 || pass1 !== 1'b0) begin
            n_bad++; $display("[TB] FAIL abort_cleared: got err %0d pass %b expected 0 0", err1, pass1);
        end
        xor_mask = 8'h00;
        run_test(-1, -1);
        check_results("after_reset");
    endtask

    task automatic test_latency_mismatch();
        clear_faults();
        lat1 = 2;
        run_test(-1, -1);
        n_cmp++;
        if (pass1 !== 1'b0) begin
            n_bad++; $display("[TB] FAIL lat_mismatch_pass: got %b expected 0", pass1);
        end
        n_cmp++;
        if (pass2 !== 1'b1 || r_b2 != 4 * DEPTH + 4) begin
            n_bad++; $display("[TB] FAIL lat2_dut2: got pass %b busy %0d expected 1 %0d", pass2, r_b2, 4 * DEPTH + 4);
        end
        lat1 = 1;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_stuck_bit();
        test_xor_all();
        test_back_to_back();
        test_reset_mid();
        test_latency_mismatch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
